// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and beat type for the rv32 fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned ILEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int unsigned PC_STEP   = 4;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } fetch_beat_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Two-entry synchronous FIFO with flush, used as fetch output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [1:0]       o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_slot [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A push into a full buffer is only accepted when a pop frees a slot.
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_slot[r_wr_ptr] <= i_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_slot[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : rv32 fetch stage: PC, registered-read IMEM and 2-entry output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     IMEM_DEPTH = 1024,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter string           INIT_FILE  = ""
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_pc,
    output logic [XLEN-1:0]               out_pc_nxt,
    output logic [ILEN-1:0]               out_instr,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [ILEN-1:0]               imem_wdata
);

    localparam int unsigned     c_idx_w   = $clog2(IMEM_DEPTH);
    localparam int unsigned     c_beat_w  = XLEN + ILEN;
    localparam logic [XLEN-1:0] c_pc_step = XLEN'(PC_STEP);

    logic [ILEN-1:0]     r_mem [IMEM_DEPTH];
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_rd_pc;
    logic [ILEN-1:0]     r_rd_instr;
    logic                r_inflight;

    logic [c_idx_w-1:0]  w_rd_idx;
    logic [1:0]          w_count;
    logic [c_beat_w-1:0] w_head;
    logic                w_valid;
    logic                w_pop;
    logic                w_issue;
    logic                w_push;
    logic                w_unused_redirect_lsbs;

    assign w_rd_idx = r_pc[c_idx_w+1:2];
    assign w_valid  = (w_count != 2'd0);
    assign w_pop    = w_valid && out_ready;

    // Buffered beats plus the one in the read register never exceed the FIFO depth.
    assign w_issue  = !redirect_valid &&
                      ((({1'b0, w_count} + {2'b00, r_inflight}) < 3'd2) || w_pop);
    assign w_push   = r_inflight && !redirect_valid;

    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_mem[imem_waddr] <= imem_wdata;
        end
        if (w_issue) begin
            r_rd_instr <= r_mem[w_rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_rd_pc    <= '0;
            r_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_pc <= r_pc;
                r_pc    <= r_pc + c_pc_step;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (c_beat_w)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({r_rd_pc, r_rd_instr}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // Idle outputs present a NOP at pc 0 rather than stale buffer contents.
    assign out_valid  = w_valid;
    assign out_pc     = w_valid ? w_head[c_beat_w-1:ILEN] : '0;
    assign out_instr  = w_valid ? w_head[ILEN-1:0] : NOP_INSTR;
    assign out_pc_nxt = out_pc + c_pc_step;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit (IMEM_DEPTH = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_nxt;
    logic [31:0] out_instr;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [31:0] imem_wdata;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    localparam logic [31:0] c_new_word = 32'hFEED_BEEF;

    fetch_unit #(
        .XLEN       (32),
        .IMEM_DEPTH (16),
        .RESET_PC   (32'h0),
        .INIT_FILE  ("")
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_pc_nxt     (out_pc_nxt),
        .out_instr      (out_instr),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_pc_nxt"}, out_pc_nxt, pc + 32'd4);
        check({tag, "_instr"}, out_instr, instr);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_pc"}, out_pc, 32'd0);
        check({tag, "_pc_nxt"}, out_pc_nxt, 32'd4);
        check({tag, "_instr"}, out_instr, 32'h00000013);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        imem_we        = 1'b0;
        imem_waddr     = '0;
        imem_wdata     = '0;
        @(negedge clk);

        // Load memory while held in reset; memory is independent of rst.
        for (int i = 0; i < 16; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 4'(i);
            imem_wdata = word(i);
            step();
        end
        imem_we = 1'b0;
        check_reset("por");

        // Stream from reset: first beat visible after E1, then one per cycle.
        rst = 1'b0;
        step();
        check("e0_valid", {31'd0, out_valid}, 32'd0);
        step();
        check_beat("s0", 32'h0, word(0));
        step();
        check_beat("s1", 32'h4, word(1));
        step();
        check_beat("s2", 32'h8, word(2));
        step();
        check_beat("s3", 32'hC, word(3));

        // Asynchronous reset mid-stream.
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rs_e0_valid", {31'd0, out_valid}, 32'd0);
        step();
        check_beat("rs0", 32'h0, word(0));
        step();
        check_beat("rs1", 32'h4, word(1));

        // Stall for five cycles with (4,B) at the head.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_pc", out_pc, 32'h4);
            check("stall_instr", out_instr, word(1));
        end
        out_ready = 1'b1;
        check_beat("rel0", 32'h4, word(1));
        step();
        check_beat("rel1", 32'h8, word(2));
        step();
        check_beat("rel2", 32'hC, word(3));

        // Fill the buffer, then redirect to an unaligned target.
        out_ready = 1'b0;
        step();
        check_beat("full_head", 32'hC, word(3));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1E;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("rd_b0_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("rd_b1_valid", {31'd0, out_valid}, 32'd0);
        step();
        check_beat("rd_t0", 32'h1C, word(7));
        step();
        check_beat("rd_t1", 32'h20, word(8));

        // Address wrap modulo 4*IMEM_DEPTH.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3C;
        step();
        redirect_valid = 1'b0;
        check("wr_b0_valid", {31'd0, out_valid}, 32'd0);
        step();
        step();
        check_beat("wrap0", 32'h3C, word(15));
        step();
        check_beat("wrap1", 32'h40, word(0));

        // Write index 2 in the same cycle pc 0x48 reads it: old word delivered.
        imem_we    = 1'b1;
        imem_waddr = 4'd2;
        imem_wdata = c_new_word;
        step();
        imem_we = 1'b0;
        check_beat("wrap2", 32'h44, word(1));
        step();
        check_beat("rw_old", 32'h48, word(2));

        // Re-fetch index 2 through a redirect: the new word is returned.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        check_beat("rw_new", 32'h8, c_new_word);
        step();
        check_beat("rw_next", 32'hC, word(3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
